// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, register-bank FSM encodings and payload types.
package axi4_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE   = 2'b00,
    W_WAIT_W = 2'b01,
    W_WAIT_A = 2'b10,
    W_RESP   = 2'b11
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Captured W beat while waiting for its address.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } w_beat_t;

endpackage

// File: rtl/axi4_lite_slave_regs_if.sv
// AXI4-Lite bus bundle between an interconnect port (master) and a register endpoint (slave).
interface axi4_lite_slave_regs_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );

endinterface

// File: rtl/axi4_lite_addr_decode.sv
// Maps a byte address onto the register window: word index, in-range and status-register flags.
module axi4_lite_addr_decode #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h2000,
  parameter int unsigned           NUM_REGS   = 8,
  parameter int unsigned           IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  in_range,
  output logic                  is_status
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] word;

  // The lower bound check keeps the subtraction from wrapping into the window.
  always_comb begin
    offset    = addr - BASE_ADDR;
    word      = offset >> 2;
    in_range  = (addr >= BASE_ADDR) && (word < ADDR_WIDTH'(NUM_REGS));
    index     = word[IDX_W-1:0];
    is_status = in_range && (index == IDX_W'(NUM_REGS - 1));
  end

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite register bank: register 0 drives ctrl_out, the top word reads status_in.
// Optional privilege check on awprot/arprot: define AXI4_LITE_SLAVE_PROT_CHECK_EN.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h0000_2000,
  parameter int unsigned           NUM_REGS   = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4_lite_slave_regs_if.slave  bus,
  input  logic [DATA_W-1:0]      status_in,
  output logic [DATA_W-1:0]      ctrl_out
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];

  w_state_e   w_state;
  r_state_e   r_state;
  logic [IDX_W-1:0] aw_idx_c, ar_idx_c, aw_idx_q, wr_idx_c;
  logic       aw_in_range_c, aw_is_status_c, ar_in_range_c, ar_is_status_c;
  logic       aw_err_c, ar_err_c, aw_err_q, wr_err_c;
  w_beat_t    w_beat_q, wr_beat_c;
  logic       aw_hs_c, w_hs_c, ar_hs_c, commit_c;

  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
  ) u_aw_dec (
    .addr(bus.awaddr), .index(aw_idx_c), .in_range(aw_in_range_c), .is_status(aw_is_status_c)
  );

  axi4_lite_addr_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)
  ) u_ar_dec (
    .addr(bus.araddr), .index(ar_idx_c), .in_range(ar_in_range_c), .is_status(ar_is_status_c)
  );

`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
  // Unprivileged accesses are rejected ahead of address decode.
  logic unused_prot;
  assign unused_prot = ^{bus.awprot[2:1], bus.arprot[2:1]};
  assign aw_err_c = !bus.awprot[0] || !aw_in_range_c || aw_is_status_c;
  assign ar_err_c = !bus.arprot[0] || !ar_in_range_c;
`else
  logic unused_prot;
  assign unused_prot = ^{bus.awprot, bus.arprot};
  assign aw_err_c = !aw_in_range_c || aw_is_status_c;
  assign ar_err_c = !ar_in_range_c;
`endif

  // Commit source: live channel when the handshake is happening now, captured copy otherwise.
  always_comb begin
    aw_hs_c   = bus.awvalid && bus.awready;
    w_hs_c    = bus.wvalid && bus.wready;
    ar_hs_c   = bus.arvalid && bus.arready;
    wr_idx_c  = aw_idx_c;
    wr_err_c  = aw_err_c;
    wr_beat_c = {bus.wdata, bus.wstrb};
    commit_c  = 1'b0;
    case (w_state)
      W_IDLE:   commit_c = aw_hs_c && w_hs_c;
      W_WAIT_W: begin
        wr_idx_c = aw_idx_q;
        wr_err_c = aw_err_q;
        commit_c = w_hs_c;
      end
      W_WAIT_A: begin
        wr_beat_c = w_beat_q;
        commit_c  = aw_hs_c;
      end
      default:  commit_c = 1'b0;
    endcase
  end

  // Write channel FSM and register bank.
  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state     <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= RESP_OKAY;
      aw_idx_q    <= '0;
      aw_err_q    <= 1'b0;
      w_beat_q    <= '0;
      regs        <= '{default: '0};
    end else if (commit_c) begin
      w_state     <= W_RESP;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b1;
      bus.bresp   <= wr_err_c ? RESP_SLVERR : RESP_OKAY;
      if (!wr_err_c) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (wr_beat_c.strb[b]) regs[wr_idx_c][8*b +: 8] <= wr_beat_c.data[8*b +: 8];
        end
      end
    end else begin
      case (w_state)
        W_IDLE: begin
          bus.awready <= 1'b1;
          bus.wready  <= 1'b1;
          if (aw_hs_c) begin
            bus.awready <= 1'b0;
            aw_idx_q    <= aw_idx_c;
            aw_err_q    <= aw_err_c;
            w_state     <= W_WAIT_W;
          end else if (w_hs_c) begin
            bus.wready  <= 1'b0;
            w_beat_q    <= wr_beat_c;
            w_state     <= W_WAIT_A;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read channel FSM; data is sampled at the AR edge, before any same-edge write lands.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rresp   <= RESP_OKAY;
      bus.rdata   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          bus.arready <= 1'b1;
          if (ar_hs_c) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b1;
            r_state     <= R_DATA;
            if (ar_err_c) begin
              bus.rdata <= '0;
              bus.rresp <= RESP_SLVERR;
            end else begin
              bus.rdata <= ar_is_status_c ? status_in : regs[ar_idx_c];
              bus.rresp <= RESP_OKAY;
            end
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            bus.rvalid  <= 1'b0;
            bus.arready <= 1'b1;
            r_state     <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign ctrl_out = regs[0];

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Scoreboard bench for axi4_lite_slave_regs; expectations come from a bench-side register model.
module tb_axi4_lite_slave_regs;

  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int          NREG = 8;
`ifdef AXI4_LITE_SLAVE_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] status_in;
  logic [31:0] ctrl_out;

  axi4_lite_slave_regs_if #(.ADDR_WIDTH(32)) bus ();

  axi4_lite_slave_regs #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .NUM_REGS(NREG)) dut (
    .aclk(aclk), .areset(areset), .bus(bus), .status_in(status_in), .ctrl_out(ctrl_out)
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl [NREG];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  function automatic bit tb_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * NREG));
  endfunction

  function automatic logic [2:0] tb_idx(input logic [31:0] a);
    return 3'((a - BASE) >> 2);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] st, input logic [2:0] p);
    bit err;
    err = !tb_in_range(a) || (tb_idx(a) == 3'(NREG - 1)) || (PROT_EN && !p[0]);
    exp_b.push_back(err ? 2'b10 : 2'b00);
    if (!err)
      for (int b = 0; b < 4; b++)
        if (st[b]) mdl[tb_idx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic model_read(input logic [31:0] a, input logic [2:0] p);
    bit err;
    logic [31:0] d;
    err = !tb_in_range(a) || (PROT_EN && !p[0]);
    if (err) d = 32'h0;
    else if (tb_idx(a) == 3'(NREG - 1)) d = status_in;
    else d = mdl[tb_idx(a)];
    exp_r.push_back({d, err ? 2'b10 : 2'b00});
  endtask

  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                           input logic [2:0] p, output bit to);
    bit ad = 0, wd = 0, ah, wh;
    bus.awaddr = a; bus.awprot = p; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = st; bus.wvalid = 1'b1;
    for (int i = 0; i < 20 && !(ad && wd); i++) begin
      @(negedge aclk);
      ah = bus.awvalid && bus.awready;
      wh = bus.wvalid && bus.wready;
      @(posedge aclk); #1;
      if (ah) begin ad = 1; bus.awvalid = 1'b0; end
      if (wh) begin wd = 1; bus.wvalid = 1'b0; end
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    to = !(ad && wd);
  endtask

  task automatic recv_b(output logic [1:0] resp, output bit to);
    bit got = 0;
    resp = 2'bxx;
    bus.bready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (bus.bvalid) begin got = 1; resp = bus.bresp; end
      @(posedge aclk); #1;
    end
    bus.bready = 1'b0;
    to = !got;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [2:0] p, output bit to);
    bit got = 0;
    bus.araddr = a; bus.arprot = p; bus.arvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      got = bus.arready;
      @(posedge aclk); #1;
    end
    bus.arvalid = 1'b0;
    to = !got;
  endtask

  task automatic recv_r(output logic [31:0] d, output logic [1:0] resp, output bit to);
    bit got = 0;
    d = 'x; resp = 2'bxx;
    bus.rready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge aclk);
      if (bus.rvalid) begin got = 1; d = bus.rdata; resp = bus.rresp; end
      @(posedge aclk); #1;
    end
    bus.rready = 1'b0;
    to = !got;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=00000", {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    checks++;
    if ({bus.rdata, bus.bresp, bus.rresp, ctrl_out} !== 68'h0) begin
      errors++;
      $display("FAIL reset_data rdata=%h bresp=%b rresp=%b ctrl=%h exp all 0", bus.rdata, bus.bresp, bus.rresp, ctrl_out);
    end
    areset = 1'b0;
    @(posedge aclk); #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b111) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=111", {bus.awready, bus.wready, bus.arready});
    end
  endtask

  task automatic test_basic();
    bit to; logic [1:0] rs, eb; logic [31:0] rd; logic [33:0] er;
    model_write(32'h2004, 32'h0000_0080, 4'hF, 3'b001);
    send_aw_w(32'h2004, 32'h0000_0080, 4'hF, 3'b001, to);
    checks++;
    if (to || bus.bvalid !== 1'b1) begin
      errors++; $display("FAIL basic_b_latency bvalid=%b exp=1 timeout=%0d", bus.bvalid, to);
    end
    recv_b(rs, to); eb = exp_b.pop_front(); checks++;
    if (to || rs !== eb) begin errors++; $display("FAIL basic_bresp got=%b exp=%b timeout=%0d", rs, eb, to); end
    model_read(32'h2004, 3'b001);
    send_ar(32'h2004, 3'b001, to);
    recv_r(rd, rs, to); er = exp_r.pop_front(); checks++;
    if (to || {rd, rs} !== er) begin
      errors++; $display("FAIL basic_read got=%h/%b exp=%h/%b timeout=%0d", rd, rs, er[33:2], er[1:0], to);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] wd [3] = '{32'h1122_3344, 32'hAABB_CCDD, 32'hFFFF_FFFF};
    logic [3:0]  ws [3] = '{4'hF, 4'h2, 4'h0};
    bit to; logic [1:0] rs, eb; logic [31:0] rd; logic [33:0] er;
    for (int i = 0; i < 3; i++) begin
      model_write(32'h2008, wd[i], ws[i], 3'b001);
      send_aw_w(32'h2008, wd[i], ws[i], 3'b001, to);
      recv_b(rs, to); eb = exp_b.pop_front(); checks++;
      if (to || rs !== eb) begin errors++; $display("FAIL strobe_bresp[%0d] got=%b exp=%b", i, rs, eb); end
      model_read(32'h2008, 3'b001);
      send_ar(32'h2008, 3'b001, to);
      recv_r(rd, rs, to); er = exp_r.pop_front(); checks++;
      if (to || {rd, rs} !== er) begin
        errors++; $display("FAIL strobe_read[%0d] got=%h/%b exp=%h/%b", i, rd, rs, er[33:2], er[1:0]);
      end
    end
  endtask

  task automatic test_w_before_aw();
    bit to; logic [1:0] rs, eb;
    model_write(32'h200C, 32'h1234_5678, 4'hF, 3'b001);
    bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    @(negedge aclk); checks++;
    if (bus.wready !== 1'b1) begin errors++; $display("FAIL wfirst_wready got=%b exp=1", bus.wready); end
    @(posedge aclk); #1; bus.wvalid = 1'b0;
    repeat (3) begin
      @(negedge aclk); checks++;
      if ({bus.wready, bus.awready, bus.bvalid} !== 3'b010) begin
        errors++; $display("FAIL wfirst_wait wready/awready/bvalid=%b exp=010", {bus.wready, bus.awready, bus.bvalid});
      end
      @(posedge aclk); #1;
    end
    bus.awaddr = 32'h200C; bus.awprot = 3'b001; bus.awvalid = 1'b1;
    @(posedge aclk); #1; bus.awvalid = 1'b0;
    eb = exp_b.pop_front();
    repeat (4) begin
      @(negedge aclk); checks++;
      if ({bus.bvalid, bus.bresp, bus.awready, bus.wready} !== {1'b1, eb, 2'b00}) begin
        errors++; $display("FAIL bhold bvalid=%b bresp=%b aw/w ready=%b%b exp 1/%b/00",
                           bus.bvalid, bus.bresp, bus.awready, bus.wready, eb);
      end
      @(posedge aclk); #1;
    end
    recv_b(rs, to); checks++;
    if (to || rs !== eb) begin errors++; $display("FAIL bhold_bresp got=%b exp=%b timeout=%0d", rs, eb, to); end
    checks++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      errors++; $display("FAIL bhold_ready_return got=%b exp=11", {bus.awready, bus.wready});
    end
  endtask

  task automatic test_errors();
    logic [31:0] wa [3] = '{32'h2020, 32'h201C, 32'h1FFC};
    bit to; logic [1:0] rs, eb; logic [31:0] rd, ra; logic [33:0] er;
    for (int i = 0; i < 3; i++) begin
      model_write(wa[i], 32'hFFFF_FFFF, 4'hF, 3'b001);
      send_aw_w(wa[i], 32'hFFFF_FFFF, 4'hF, 3'b001, to);
      recv_b(rs, to); eb = exp_b.pop_front(); checks++;
      if (to || rs !== eb) begin errors++; $display("FAIL err_bresp[%h] got=%b exp=%b", wa[i], rs, eb); end
    end
    status_in = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      ra = (i == 9) ? 32'h1FFC : BASE + 32'(4 * i);
      model_read(ra, 3'b001);
      send_ar(ra, 3'b001, to);
      recv_r(rd, rs, to); er = exp_r.pop_front(); checks++;
      if (to || {rd, rs} !== er) begin
        errors++; $display("FAIL sweep_read[%h] got=%h/%b exp=%h/%b", ra, rd, rs, er[33:2], er[1:0]);
      end
    end
  endtask

  task automatic test_same_edge();
    bit to_w, to_r, to; logic [1:0] rs, eb; logic [31:0] rd, ec; logic [33:0] er;
    model_read(32'h2000, 3'b001);
    model_write(32'h2000, 32'h0000_0055, 4'hF, 3'b001);
    ec = mdl[0];
    fork
      send_aw_w(32'h2000, 32'h0000_0055, 4'hF, 3'b001, to_w);
      send_ar(32'h2000, 3'b001, to_r);
      begin
        @(negedge aclk); @(posedge aclk); #1;
        checks++;
        if (ctrl_out !== ec) begin errors++; $display("FAIL ctrl_out_next got=%h exp=%h", ctrl_out, ec); end
      end
    join
    recv_b(rs, to); eb = exp_b.pop_front(); checks++;
    if (to || to_w || rs !== eb) begin errors++; $display("FAIL same_edge_bresp got=%b exp=%b", rs, eb); end
    recv_r(rd, rs, to); er = exp_r.pop_front(); checks++;
    if (to || to_r || {rd, rs} !== er) begin
      errors++; $display("FAIL same_edge_read got=%h/%b exp=%h/%b", rd, rs, er[33:2], er[1:0]);
    end
    model_read(32'h2000, 3'b001);
    send_ar(32'h2000, 3'b001, to);
    recv_r(rd, rs, to); er = exp_r.pop_front(); checks++;
    if (to || {rd, rs} !== er) begin
      errors++; $display("FAIL reread got=%h/%b exp=%h/%b", rd, rs, er[33:2], er[1:0]);
    end
  endtask

  task automatic test_reset_abort_and_prot();
    bit to; logic [1:0] rs, eb; logic [31:0] rd; logic [33:0] er;
    send_aw_w(32'h2004, 32'hA5A5_A5A5, 4'hF, 3'b001, to);
    send_ar(32'h2004, 3'b001, to);
    @(negedge aclk); checks++;
    if ({bus.bvalid, bus.rvalid} !== 2'b11) begin
      errors++; $display("FAIL abort_setup bvalid/rvalid=%b exp=11", {bus.bvalid, bus.rvalid});
    end
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk); #1;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready} !== 5'b0 || ctrl_out !== 32'h0) begin
      errors++; $display("FAIL abort_reset b/r valid, readies=%b ctrl=%h exp 00000/0",
                         {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready}, ctrl_out);
    end
    areset = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
    @(posedge aclk); #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
      errors++; $display("FAIL abort_release got=%b exp=11100",
                         {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    model_write(32'h2018, 32'h0BAD_F00D, 4'hF, 3'b000);
    send_aw_w(32'h2018, 32'h0BAD_F00D, 4'hF, 3'b000, to);
    recv_b(rs, to); eb = exp_b.pop_front(); checks++;
    if (to || rs !== eb) begin errors++; $display("FAIL prot_bresp got=%b exp=%b", rs, eb); end
    for (int i = 0; i < 2; i++) begin
      model_read(32'h2018, 3'(i));
      send_ar(32'h2018, 3'(i), to);
      recv_r(rd, rs, to); er = exp_r.pop_front(); checks++;
      if (to || {rd, rs} !== er) begin
        errors++; $display("FAIL prot_read[arprot=%0d] got=%h/%b exp=%h/%b", i, rd, rs, er[33:2], er[1:0]);
      end
    end
  endtask

  initial begin
    areset = 1'b1; status_in = 32'h0;
    bus.awaddr = '0; bus.awprot = 3'b001; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = 3'b001; bus.arvalid = 1'b0; bus.rready = 1'b0;
    for (int i = 0; i < NREG; i++) mdl[i] = 32'h0;
    test_reset();
    test_basic();
    test_strobe();
    test_w_before_aw();
    test_errors();
    test_same_edge();
    test_reset_abort_and_prot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
